crf_node_sram: RTL and testbench
================================

CRF_NODE_SRAM -- requirements
Module: crf_node_sram

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, word width in bits; signed two's complement.
- DEPTH, 16, number of node entries.
- ADDR_WIDTH, 4, nodeIndex width; 2^ADDR_WIDTH >= DEPTH.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- cellEnable, in, 1, command strobe; sampled only when ready=1.
- writeEnable, in, 1, 1 = write or accumulate, 0 = read.
- accumulate, in, 1, with writeEnable=1 selects read-modify-write add.
- clearAll, in, 1, with cellEnable=1 zeroes every entry.
- nodeIndex, in, ADDR_WIDTH, entry address.
- inData, in, DATA_WIDTH, write data or addend.
- outData, out, DATA_WIDTH, registered read data; never tri-stated.
- outValid, out, 1, one-cycle pulse marking outData valid.
- ready, out, 1, block accepts a command this cycle.
- saturated, out, 1, one-cycle pulse when an accumulate clipped.
- indexError, out, 1, one-cycle pulse when nodeIndex >= DEPTH.

Function
REQ-003 A command SHALL be accepted on a rising edge only when cellEnable=1 and ready=1; all other cycles are ignored.
REQ-004 Decode priority SHALL be: clearAll, then accumulate (writeEnable=1, accumulate=1), then write (writeEnable=1), then read (writeEnable=0; accumulate ignored).
REQ-005 FSM states SHALL be IDLE, CLEAR and ACC_WB; ready=1 only in IDLE.
REQ-006 Write SHALL update mem[nodeIndex] at the accepting edge, complete in 1 cycle, and leave outValid low.
REQ-007 Read SHALL load outData with mem[nodeIndex] at the accepting edge; outValid=1 for exactly the following cycle.
REQ-008 outData SHALL hold its last value when outValid=0.
REQ-009 Read-after-write to the same index on consecutive cycles SHALL return the new data.
REQ-010 Accumulate SHALL capture mem[nodeIndex] and inData at the accepting edge (IDLE->ACC_WB), then write back their sum on the next edge (ACC_WB->IDLE); ready=0 for that one cycle.
REQ-011 The accumulate sum SHALL be a signed DATA_WIDTH add saturating to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
REQ-012 saturated SHALL pulse in the cycle after the write-back when clipping occurred.
REQ-013 Accumulate SHALL not drive outValid.
REQ-014 Clear SHALL move IDLE->CLEAR and zero entries 0..DEPTH-1 one per cycle using an internal counter, with ready=0 for exactly DEPTH cycles, then return to IDLE.
REQ-015 If nodeIndex >= DEPTH, a write, accumulate or clear-free command SHALL leave memory unchanged.
REQ-016 If nodeIndex >= DEPTH, a read SHALL return 0 with outValid.
REQ-017 Every out-of-range command SHALL pulse indexError for one cycle after acceptance.
REQ-018 Inputs presented while ready=0 SHALL have no effect and SHALL not be queued.

Reset
REQ-019 reset=1 SHALL force outData=0, outValid=0, saturated=0, indexError=0, ready=0, clear counter=0, and state CLEAR.
REQ-020 On reset release, the block SHALL zero all entries; ready rises after DEPTH cycles.
REQ-021 Reset mid-clear SHALL restart the sweep at entry 0.
REQ-022 Reset in ACC_WB SHALL abort the pending write-back; the entry is then zeroed by the clear sweep.

Verification
REQ-023 Post-reset: release reset -> ready=0 for 16 cycles, then 1; read index 5 -> outData=0x00000000 with outValid=1.
REQ-024 Write/read: write 0xFFFFFFFF to index 3, read index 3 next cycle -> outData=0xFFFFFFFF, outValid pulse of 1 cycle.
REQ-025 Accumulate: index 2=0x00000010, accumulate 0x00000005 -> ready low 1 cycle, subsequent read 0x00000015, saturated=0.
REQ-026 Saturation: 0x7FFFFFF0 + 0x00000020 -> 0x7FFFFFFF and 0x80000005 + 0xFFFFFFF0 -> 0x80000000, each with a saturated pulse.
REQ-027 Range (DEPTH=12, ADDR_WIDTH=4): write 0x1234 to index 13 -> indexError pulse; read index 13 -> 0 with indexError; index 0..11 unchanged.
REQ-028 Reset mid-op: assert reset in cycle 7 of clearAll and during ACC_WB -> 16 fresh clear cycles follow and all entries read 0.

Source files
------------

// File: rtl/crf_node_sram.sv
// rtl/crf_node_sram.sv - node-value register file with write, read, saturating accumulate and sweep clear
//
// Purpose:
//   Holds DEPTH signed DATA_WIDTH-bit node values. Accepts one command per
//   cycle while ready is high: clear-all (sweeps every entry to zero, one per
//   cycle), saturating accumulate (read-modify-write over two cycles), plain
//   write (single cycle) and registered read. Out-of-range indices never touch
//   the array and raise a one-cycle indexError pulse.
//
// Ports:
//   clk          single rising-edge clock
//   reset        synchronous, active-high; leaves the block sweeping to zero
//   cellEnable   command strobe, honoured only while ready=1
//   writeEnable  1 = write / accumulate, 0 = read
//   accumulate   with writeEnable=1 selects the saturating read-modify-write add
//   clearAll     with cellEnable=1 zeroes every entry (highest priority)
//   nodeIndex    entry address
//   inData       write data or addend
//   outData      registered read data, holds when outValid=0
//   outValid     one-cycle pulse marking outData valid
//   ready        block accepts a command this cycle
//   saturated    one-cycle pulse after a clipped accumulate write-back
//   indexError   one-cycle pulse after accepting an out-of-range command

module crf_node_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cellEnable,
  input  logic                  writeEnable,
  input  logic                  accumulate,
  input  logic                  clearAll,
  input  logic [ADDR_WIDTH-1:0] nodeIndex,
  input  logic [DATA_WIDTH-1:0] inData,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  output logic                  ready,
  output logic                  saturated,
  output logic                  indexError
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX    = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN    = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACC_WB = 2'd2
  } state_t;

  state_t state;
  state_t nextState;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] clearCount;

  // Pending accumulate operands, captured at the accepting edge.
  logic [DATA_WIDTH-1:0] accBase;
  logic [DATA_WIDTH-1:0] accAddend;
  logic [ADDR_WIDTH-1:0] accIndex;
  logic                  accInRange;

  logic                  accept;
  logic                  cmdClear;
  logic                  cmdAcc;
  logic                  cmdWrite;
  logic                  cmdRead;
  logic                  inRange;
  logic [DATA_WIDTH-1:0] memReadData;

  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;

  logic [DATA_WIDTH:0]   wideSum;
  logic                  accOverflow;
  logic [DATA_WIDTH-1:0] accResult;

  // ---------------------------------------------------------------------------
  // Command decode: clear beats accumulate beats write beats read.
  // ---------------------------------------------------------------------------
  assign accept   = cellEnable & ready;
  assign cmdClear = accept & clearAll;
  assign cmdAcc   = accept & ~clearAll & writeEnable & accumulate;
  assign cmdWrite = accept & ~clearAll & writeEnable & ~accumulate;
  assign cmdRead  = accept & ~clearAll & ~writeEnable;

  // Zero-extend so the compare stays meaningful when DEPTH == 2**ADDR_WIDTH.
  assign inRange     = ({1'b0, nodeIndex} < DEPTH_EXT);
  assign memReadData = inRange ? mem[nodeIndex] : '0;

  // ---------------------------------------------------------------------------
  // Saturating signed add. Overflow shows as the two top bits of the
  // sign-extended sum disagreeing; the true sign picks the rail.
  // ---------------------------------------------------------------------------
  assign wideSum     = {accBase[DATA_WIDTH-1], accBase} + {accAddend[DATA_WIDTH-1], accAddend};
  assign accOverflow = wideSum[DATA_WIDTH] ^ wideSum[DATA_WIDTH-1];

  always_comb begin
    accResult = wideSum[DATA_WIDTH-1:0];
    if (accOverflow) begin
      accResult = wideSum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (cmdClear) begin
          nextState = CLEAR;
        end else if (cmdAcc) begin
          nextState = ACC_WB;
        end
      end
      CLEAR: begin
        if (clearCount == LAST_ENTRY) begin
          nextState = IDLE;
        end
      end
      ACC_WB:  nextState = IDLE;
      default: nextState = CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Gating with reset keeps a command from being taken in the
  // very cycle reset is raised.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (state == IDLE) & ~reset;
  end

  // ---------------------------------------------------------------------------
  // Sweep counter: sits at 0 outside CLEAR so every sweep starts at entry 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      clearCount <= '0;
    end else if (state == CLEAR && clearCount != LAST_ENTRY) begin
      clearCount <= clearCount + 1'b1;
    end else begin
      clearCount <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate operand capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      accBase    <= '0;
      accAddend  <= '0;
      accIndex   <= '0;
      accInRange <= 1'b0;
    end else if (cmdAcc) begin
      accBase    <= memReadData;
      accAddend  <= inData;
      accIndex   <= nodeIndex;
      accInRange <= inRange;
    end
  end

  // ---------------------------------------------------------------------------
  // Single array write port shared by sweep, accumulate write-back and write.
  // The three sources are mutually exclusive by state.
  // ---------------------------------------------------------------------------
  always_comb begin
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    case (state)
      CLEAR: begin
        memWe   = 1'b1;
        memAddr = clearCount;
      end
      ACC_WB: begin
        memWe    = accInRange;
        memAddr  = accIndex;
        memWdata = accResult;
      end
      default: begin
        memWe    = cmdWrite & inRange;
        memAddr  = nodeIndex;
        memWdata = inData;
      end
    endcase
  end

  // Reset suppresses the write so an interrupted accumulate never lands.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem[memAddr] <= memWdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      outData    <= '0;
      outValid   <= 1'b0;
      saturated  <= 1'b0;
      indexError <= 1'b0;
    end else begin
      outValid   <= cmdRead;
      if (cmdRead) begin
        outData <= memReadData;
      end
      saturated  <= (state == ACC_WB) & accInRange & accOverflow;
      indexError <= (cmdRead | cmdWrite | cmdAcc) & ~inRange;
    end
  end

endmodule

// File: tb/tb_crf_node_sram.sv
// tb/tb_crf_node_sram.sv - scoreboard bench for crf_node_sram (DEPTH=16 and DEPTH=12 instances)

module tb_crf_node_sram;

  logic        clk = 1'b0;
  logic        reset       [2];
  logic        cellEnable  [2];
  logic        writeEnable [2];
  logic        accumulate  [2];
  logic        clearAll    [2];
  logic [3:0]  nodeIndex   [2];
  logic [31:0] inData      [2];
  logic [31:0] outData     [2];
  logic        outValid    [2];
  logic        ready       [2];
  logic        saturated   [2];
  logic        indexError  [2];

  int applied     = 0;
  int miscompares = 0;

  typedef struct {
    int          s;
    logic [31:0] d;
    logic        ie;
    string       name;
  } exp_t;

  exp_t expQ[$];
  exp_t monItem;

  always #5 clk = ~clk;

  crf_node_sram #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4)) dut0 (
    .clk(clk), .reset(reset[0]), .cellEnable(cellEnable[0]), .writeEnable(writeEnable[0]),
    .accumulate(accumulate[0]), .clearAll(clearAll[0]), .nodeIndex(nodeIndex[0]),
    .inData(inData[0]), .outData(outData[0]), .outValid(outValid[0]), .ready(ready[0]),
    .saturated(saturated[0]), .indexError(indexError[0])
  );

  crf_node_sram #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset[1]), .cellEnable(cellEnable[1]), .writeEnable(writeEnable[1]),
    .accumulate(accumulate[1]), .clearAll(clearAll[1]), .nodeIndex(nodeIndex[1]),
    .inData(inData[1]), .outData(outData[1]), .outValid(outValid[1]), .ready(ready[1]),
    .saturated(saturated[1]), .indexError(indexError[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every outValid pulse consumes the oldest expected read.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (outValid[s]) begin
        if (expQ.size() == 0 || expQ[0].s != s) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_outValid dut%0d: got data 0x%08h, expected no read", s, outData[s]);
        end else begin
          monItem = expQ.pop_front();
          check(monItem.name, outData[s], monItem.d);
          check({monItem.name, "_indexError"}, {31'b0, indexError[s]}, {31'b0, monItem.ie});
        end
      end
    end
  end

  task automatic waitReady(input int s);
    int n = 0;
    while (!ready[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready[s]) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Counts cycles with ready low, starting in the current cycle.
  task automatic countBusy(input int s, output int n);
    n = 0;
    while (!ready[s] && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic cmd(input int s, input logic clr, input logic we, input logic acc,
                     input logic [3:0] idx, input logic [31:0] d);
    waitReady(s);
    cellEnable[s]  = 1'b1;
    clearAll[s]    = clr;
    writeEnable[s] = we;
    accumulate[s]  = acc;
    nodeIndex[s]   = idx;
    inData[s]      = d;
    @(negedge clk);
    cellEnable[s]  = 1'b0;
    clearAll[s]    = 1'b0;
  endtask

  task automatic doWrite(input int s, input logic [3:0] idx, input logic [31:0] d, input logic expIe);
    cmd(s, 1'b0, 1'b1, 1'b0, idx, d);
    check($sformatf("write%0d_%0d_indexError", s, idx), {31'b0, indexError[s]}, {31'b0, expIe});
  endtask

  task automatic doRead(input int s, input logic [3:0] idx, input logic [31:0] expD, input logic expIe);
    exp_t e;
    e.s = s; e.d = expD; e.ie = expIe;
    e.name = $sformatf("read%0d_idx%0d", s, idx);
    expQ.push_back(e);
    cmd(s, 1'b0, 1'b0, 1'b0, idx, 32'h0);
    @(negedge clk);
    check($sformatf("read%0d_idx%0d_pulse_end", s, idx), {31'b0, outValid[s]}, 32'd0);
  endtask

  task automatic doAcc(input int s, input logic [3:0] idx, input logic [31:0] d,
                       input logic expSat, input logic expIe);
    cmd(s, 1'b0, 1'b1, 1'b1, idx, d);
    check("acc_ready_low", {31'b0, ready[s]}, 32'd0);
    check("acc_indexError", {31'b0, indexError[s]}, {31'b0, expIe});
    check("acc_no_outValid", {31'b0, outValid[s]}, 32'd0);
    @(negedge clk);
    check("acc_ready_back", {31'b0, ready[s]}, 32'd1);
    check("acc_saturated", {31'b0, saturated[s]}, {31'b0, expSat});
    @(negedge clk);
    check("acc_saturated_end", {31'b0, saturated[s]}, 32'd0);
  endtask

  task automatic resetChecks(input int s);
    check("rst_outData", outData[s], 32'd0);
    check("rst_outValid", {31'b0, outValid[s]}, 32'd0);
    check("rst_ready", {31'b0, ready[s]}, 32'd0);
    check("rst_saturated", {31'b0, saturated[s]}, 32'd0);
    check("rst_indexError", {31'b0, indexError[s]}, 32'd0);
  endtask

  initial begin
    int n;
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b1; cellEnable[s] = 1'b0; writeEnable[s] = 1'b0; accumulate[s] = 1'b0;
      clearAll[s] = 1'b0; nodeIndex[s] = 4'd0; inData[s] = 32'd0;
    end
    repeat (3) @(negedge clk);
    resetChecks(0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    countBusy(0, n);
    check("post_reset_busy_cycles", n, 32'd16);

    doRead(0, 4'd5, 32'h0, 1'b0);

    doWrite(0, 4'd3, 32'hFFFF_FFFF, 1'b0);
    doRead(0, 4'd3, 32'hFFFF_FFFF, 1'b0);

    doWrite(0, 4'd2, 32'h0000_0010, 1'b0);
    doAcc(0, 4'd2, 32'h0000_0005, 1'b0, 1'b0);
    doRead(0, 4'd2, 32'h0000_0015, 1'b0);

    doWrite(0, 4'd4, 32'h7FFF_FFF0, 1'b0);
    doAcc(0, 4'd4, 32'h0000_0020, 1'b1, 1'b0);
    doRead(0, 4'd4, 32'h7FFF_FFFF, 1'b0);

    doWrite(0, 4'd6, 32'h8000_0005, 1'b0);
    doAcc(0, 4'd6, 32'hFFFF_FFF0, 1'b1, 1'b0);
    doRead(0, 4'd6, 32'h8000_0000, 1'b0);

    // Range handling on the DEPTH=12 instance.
    for (int i = 0; i < 12; i++) doWrite(1, 4'(i), 32'h100 + 32'(i), 1'b0);
    doWrite(1, 4'd13, 32'h0000_1234, 1'b1);
    @(negedge clk);
    check("oor_write_pulse_end", {31'b0, indexError[1]}, 32'd0);
    doAcc(1, 4'd12, 32'h0000_0001, 1'b0, 1'b1);
    doRead(1, 4'd13, 32'h0, 1'b1);
    for (int i = 0; i < 12; i++) doRead(1, 4'(i), 32'h100 + 32'(i), 1'b0);

    // Reset in cycle 7 of a clear sweep.
    doWrite(0, 4'd7, 32'h0000_00A5, 1'b0);
    doWrite(0, 4'd15, 32'h0000_005A, 1'b0);
    cmd(0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    repeat (6) @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    resetChecks(0);
    reset[0] = 1'b0;
    countBusy(0, n);
    check("midclear_busy_cycles", n, 32'd16);
    for (int i = 0; i < 16; i++) doRead(0, 4'(i), 32'h0, 1'b0);

    // Reset while an accumulate write-back is pending.
    doWrite(0, 4'd9, 32'h0000_0055, 1'b0);
    cmd(0, 1'b0, 1'b1, 1'b1, 4'd9, 32'h0000_0001);
    check("accwb_ready_low", {31'b0, ready[0]}, 32'd0);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    countBusy(0, n);
    check("accwb_busy_cycles", n, 32'd16);
    for (int i = 0; i < 16; i++) doRead(0, 4'(i), 32'h0, 1'b0);

    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
